alu_rs: RTL and testbench
=========================

# alu_rs

ALU reservation station for the out-of-order pipeline. It sits between the ID/DP stage and the EX stage and holds up to `DEPTH` dispatched ALU/branch/jump instructions. Each entry waits until both source operands are available, capturing them from the common data bus (CDB) by ROB tag. Each cycle it issues the oldest fully-ready entry to EX, supplying operand data, `pc_1`, the instruction word and the control bits EX consumes.

## Interface
Parameters:
- `DEPTH`, 4: number of entries, 2..8.
- `TAG_W`, 5: ROB tag width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all entries (mispredict recovery).
- `dp_valid`  in  1  dispatch request.
- `dp_ready`  out  1  station can accept a dispatch this cycle.
- `dp_rob_tag`  in  TAG_W  destination ROB tag.
- `dp_rs_rdy`, `dp_rt_rdy`  in  1 each  operand already valid at dispatch.
- `dp_rs_tag`, `dp_rt_tag`  in  TAG_W each  producer tag, used when the operand is not ready.
- `dp_rs_data`, `dp_rt_data`  in  32 each  operand value, used when the operand is ready.
- `dp_pc_1`, `dp_instr`  in  32 each  PC+1 and instruction word.
- `dp_ctrl`  in  9  {ldic, isSignEx, immed, alu_ctrl3..0, isJump, isJR}.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  broadcast tag.
- `cdb_data`  in  32  broadcast value.
- `iss_valid`  out  1  an entry is being presented to EX.
- `iss_ready`  in  1  EX accepts; issue fires when `iss_valid & iss_ready`.
- `iss_rob_tag`  out  TAG_W  issuing entry's ROB tag.
- `iss_rs_data`, `iss_rt_data`, `iss_pc_1`, `iss_instr`  out  32 each  issuing entry's fields.
- `iss_ctrl`  out  9  issuing entry's control bits.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: a collapsing queue. Entry 0 is the oldest. Occupied entries are always contiguous from index 0.
- Per-entry state: valid, rob_tag, and for each operand {rdy, tag, data}, plus pc_1, instr and ctrl.
- Dispatch fires on `dp_valid & dp_ready`. The new entry is written at index `count`, or at `count-1` when an issue fires in the same cycle.
- Dispatch-time CDB bypass: if a dispatched operand has `rdy=0` and `cdb_valid` with `cdb_tag` equal to its tag in the same cycle, the entry is written with that operand ready and holding `cdb_data`.
- Wakeup: every valid entry compares each non-ready operand tag with `cdb_tag` when `cdb_valid` is high. On a match it sets rdy and latches `cdb_data`. Both operands of one entry may match the same broadcast.
- The rt operand is tracked even for immediate-form instructions. ID/DP marks it ready at dispatch when it is unused.
- Select: the lowest-index valid entry with both operands ready. `iss_*` outputs are combinational from that entry's stored registers. The CDB never bypasses directly onto `iss_*`.
- On an issue fire, the selected entry is removed and all younger entries shift down by one. A wakeup that occurs in the same cycle applies to the entries' shifted positions.
- When no entry is selected, `iss_*` data outputs hold the value of entry 0's fields (don't-care). `iss_valid` is 0.
- `dp_ready = (count < DEPTH)`. A slot freed by an issue in the same cycle does not raise `dp_ready`.
- `flush`: all valid bits clear next edge and `count` becomes 0. `flush` has priority over a same-cycle dispatch, issue and wakeup. `iss_valid` is forced to 0 while `flush` is high.
- Reset (`rst_n` low, asynchronous): all valid bits and `count` go to 0. Consequently `iss_valid`=0 and `dp_ready`=1. Data fields need not be reset.

## Timing
- Dispatch with both operands ready in cycle N: the entry can issue in cycle N+1, with `iss_valid` high in N+1 if it is the oldest ready entry.
- CDB wakeup in cycle N: the entry can issue in N+1.
- Dispatch bypass in cycle N: the entry can issue in N+1.
- Throughput is one issue per cycle and one dispatch per cycle.
- `count` update per edge: +1 on dispatch only, -1 on issue only, unchanged when both fire. It cannot exceed `DEPTH` or fall below 0.
- `iss_valid` high with `iss_ready` low: the station stalls. The same entry stays selected with stable outputs unless an older entry becomes ready. Older-first selection may switch the presented entry; EX samples only on fire.
- Reset deasserted mid-operation: the station starts empty; no stale issue is possible.

## Test plan
- Ready dispatch: `DEPTH`=4; dispatch rob_tag 3 with rs=0x10 and rt=0x20 both ready, `iss_ready`=1 → next cycle `iss_valid`=1, `iss_rob_tag`=3, `iss_rs_data`=0x10; the following cycle `count`=0.
- Wakeup: dispatch with rs not ready (tag 7); hold 3 cycles with `iss_valid`=0; drive a CDB broadcast with tag 7 and data 0xABCD → `iss_valid`=1 one cycle later with `iss_rs_data`=0xABCD.
- Dispatch bypass: dispatch with rt tag 5 not ready while the CDB carries tag 5 and data 0x55 in the same cycle → next cycle the entry issues with `iss_rt_data`=0x55.
- Age order: fill 4 entries (A, B, C, D) with `iss_ready`=0, then make C ready, then A ready → C is presented first; after A becomes ready A is presented; with `iss_ready`=1 the issue order is A, C. `dp_ready`=0 while `count`=4.
- Full with simultaneous events: at `count`=4, issue plus a `dp_valid` request → no dispatch (`dp_ready`=0), `count`=3. Next cycle issue plus dispatch → `count` stays 3.
- Flush/reset: with 3 entries, assert `flush` alongside `dp_valid` → `count`=0 next cycle and no issue; pulse `rst_n` low mid-stream → immediately `iss_valid`=0 and `dp_ready`=1.

Source files
------------

// File: rtl/alu_rs_if.sv
`default_nettype none
// ============================================================================
// Module : alu_rs_if
// Dispatch, CDB and issue bundle of the ALU reservation station.
// Rev    : 1.0
// ============================================================================
interface alu_rs_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             dp_valid;
  logic             dp_ready;
  logic [TAG_W-1:0] dp_rob_tag;
  logic             dp_rs_rdy;
  logic             dp_rt_rdy;
  logic [TAG_W-1:0] dp_rs_tag;
  logic [TAG_W-1:0] dp_rt_tag;
  logic [31:0]      dp_rs_data;
  logic [31:0]      dp_rt_data;
  logic [31:0]      dp_pc_1;
  logic [31:0]      dp_instr;
  logic [8:0]       dp_ctrl;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  logic             iss_valid;
  logic             iss_ready;
  logic [TAG_W-1:0] iss_rob_tag;
  logic [31:0]      iss_rs_data;
  logic [31:0]      iss_rt_data;
  logic [31:0]      iss_pc_1;
  logic [31:0]      iss_instr;
  logic [8:0]       iss_ctrl;

  logic [CNT_W-1:0] count;

  modport master (
    output dp_valid, dp_rob_tag, dp_rs_rdy, dp_rt_rdy, dp_rs_tag, dp_rt_tag,
           dp_rs_data, dp_rt_data, dp_pc_1, dp_instr, dp_ctrl,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  dp_ready, iss_valid, iss_rob_tag, iss_rs_data, iss_rt_data,
           iss_pc_1, iss_instr, iss_ctrl, count
  );

  modport slave (
    input  dp_valid, dp_rob_tag, dp_rs_rdy, dp_rt_rdy, dp_rs_tag, dp_rt_tag,
           dp_rs_data, dp_rt_data, dp_pc_1, dp_instr, dp_ctrl,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output dp_ready, iss_valid, iss_rob_tag, iss_rs_data, iss_rt_data,
           iss_pc_1, iss_instr, iss_ctrl, count
  );
endinterface
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module : alu_rs
// Collapsing-queue ALU reservation station: CDB wakeup, oldest-ready issue.
// Rev    : 1.0
// ============================================================================
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  alu_rs_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic             rs_rdy;
    logic [TAG_W-1:0] rs_tag;
    logic [31:0]      rs_data;
    logic             rt_rdy;
    logic [TAG_W-1:0] rt_tag;
    logic [31:0]      rt_data;
    logic [31:0]      pc_1;
    logic [31:0]      instr;
    logic [8:0]       ctrl;
  } entry_t;

  logic [DEPTH-1:0] r_valid;
  entry_t           r_ent [DEPTH];
  logic [CNT_W-1:0] r_count;

  // Woken copy of each entry; index DEPTH is an empty slot shifted into the top.
  logic [DEPTH:0]   w_wk_v;
  entry_t           w_wk [DEPTH+1];
  entry_t           w_new;
  logic [DEPTH-1:0] w_nxt_v;
  entry_t           w_nxt [DEPTH];
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_dp_pos;
  logic [DEPTH-1:0] w_sel_oh;
  logic [DEPTH-1:0] w_shift;
  logic             w_any;
  logic             w_iss_fire;
  logic             w_dp_fire;

  assign bus.dp_ready  = (r_count < CNT_W'(DEPTH));
  assign bus.iss_valid = w_any & ~flush;
  assign bus.count     = r_count;
  assign w_iss_fire    = bus.iss_valid & bus.iss_ready;
  assign w_dp_fire     = bus.dp_valid & bus.dp_ready & ~flush;
  assign w_dp_pos      = r_count - CNT_W'(w_iss_fire);

  always_comb begin
    w_wk_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wk_v[i] = r_valid[i];
      w_wk[i]   = r_ent[i];
      if (bus.cdb_valid && r_valid[i]) begin
        if (!r_ent[i].rs_rdy && (r_ent[i].rs_tag == bus.cdb_tag)) begin
          w_wk[i].rs_rdy  = 1'b1;
          w_wk[i].rs_data = bus.cdb_data;
        end
        if (!r_ent[i].rt_rdy && (r_ent[i].rt_tag == bus.cdb_tag)) begin
          w_wk[i].rt_rdy  = 1'b1;
          w_wk[i].rt_data = bus.cdb_data;
        end
      end
    end
    w_wk[DEPTH] = '0;
  end

  // Oldest ready entry; with nothing ready the data outputs follow entry 0.
  always_comb begin
    w_sel_oh        = '0;
    w_any           = 1'b0;
    bus.iss_rob_tag = r_ent[0].rob_tag;
    bus.iss_rs_data = r_ent[0].rs_data;
    bus.iss_rt_data = r_ent[0].rt_data;
    bus.iss_pc_1    = r_ent[0].pc_1;
    bus.iss_instr   = r_ent[0].instr;
    bus.iss_ctrl    = r_ent[0].ctrl;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_any && r_valid[i] && r_ent[i].rs_rdy && r_ent[i].rt_rdy) begin
        w_sel_oh[i]     = 1'b1;
        w_any           = 1'b1;
        bus.iss_rob_tag = r_ent[i].rob_tag;
        bus.iss_rs_data = r_ent[i].rs_data;
        bus.iss_rt_data = r_ent[i].rt_data;
        bus.iss_pc_1    = r_ent[i].pc_1;
        bus.iss_instr   = r_ent[i].instr;
        bus.iss_ctrl    = r_ent[i].ctrl;
      end
    end
  end

  // Entries at and above the issued slot collapse down by one.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    w_shift = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc        = acc | w_sel_oh[i];
      w_shift[i] = w_iss_fire & acc;
    end
  end

  always_comb begin
    w_new.rob_tag = bus.dp_rob_tag;
    w_new.rs_rdy  = bus.dp_rs_rdy;
    w_new.rs_tag  = bus.dp_rs_tag;
    w_new.rs_data = bus.dp_rs_data;
    w_new.rt_rdy  = bus.dp_rt_rdy;
    w_new.rt_tag  = bus.dp_rt_tag;
    w_new.rt_data = bus.dp_rt_data;
    w_new.pc_1    = bus.dp_pc_1;
    w_new.instr   = bus.dp_instr;
    w_new.ctrl    = bus.dp_ctrl;
    if (!bus.dp_rs_rdy && bus.cdb_valid && (bus.cdb_tag == bus.dp_rs_tag)) begin
      w_new.rs_rdy  = 1'b1;
      w_new.rs_data = bus.cdb_data;
    end
    if (!bus.dp_rt_rdy && bus.cdb_valid && (bus.cdb_tag == bus.dp_rt_tag)) begin
      w_new.rt_rdy  = 1'b1;
      w_new.rt_data = bus.cdb_data;
    end
  end

  always_comb begin
    w_nxt_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt_v[i] = w_shift[i] ? w_wk_v[i+1] : w_wk_v[i];
      w_nxt[i]   = w_shift[i] ? w_wk[i+1]   : w_wk[i];
      if (w_dp_fire && (w_dp_pos == CNT_W'(i))) begin
        w_nxt_v[i] = 1'b1;
        w_nxt[i]   = w_new;
      end
      if (flush) begin
        w_nxt_v[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_dp_fire && !w_iss_fire) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_dp_fire && w_iss_fire) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_nxt_v;
      r_count <= w_count_nxt;
    end
  end

  // Payload is qualified by r_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      r_ent[i] <= w_nxt[i];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_alu_rs
// Vector table, hand sequences and randomized queue-model check of alu_rs.
// Rev    : 1.0
// ============================================================================
module tb_alu_rs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int N_RAND = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_rs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  typedef struct {
    logic fl, dv, ir, rsr, rtr, cv;
    logic [TAG_W-1:0] tag, rs_tg, rt_tg, ct;
    logic [31:0] rsd, rtd, cd, pc, ins;
    logic [8:0] ctl;
  } in_t;

  typedef struct {
    in_t in;
    logic ev, edr;
    logic [TAG_W-1:0] et;
    logic [31:0] ers, ert;
    logic [CNT_W-1:0] ec;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag, rs_tag, rt_tag;
    logic rs_rdy, rt_rdy;
    logic [31:0] rs, rt, pc, ins;
    logic [8:0] ctl;
  } m_ent_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  m_ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int fl, dv, tag, rsr, rsg, rsd, rtr, rtg, rtd,
                              cv, ct, cd, ir, ev, et, ers, ert, edr, ec);
    vec_t v;
    v.in.fl = (fl != 0);   v.in.dv = (dv != 0);   v.in.ir = (ir != 0);
    v.in.rsr = (rsr != 0); v.in.rtr = (rtr != 0); v.in.cv = (cv != 0);
    v.in.tag = TAG_W'(tag); v.in.rs_tg = TAG_W'(rsg); v.in.rt_tg = TAG_W'(rtg);
    v.in.ct = TAG_W'(ct);
    v.in.rsd = 32'(rsd); v.in.rtd = 32'(rtd); v.in.cd = 32'(cd);
    v.in.pc = 32'h1000 + 32'(tag); v.in.ins = 32'hE000_0000 | 32'(tag);
    v.in.ctl = 9'(tag * 3);
    v.ev = (ev != 0); v.edr = (edr != 0); v.et = TAG_W'(et);
    v.ers = 32'(ers); v.ert = 32'(ert); v.ec = CNT_W'(ec);
    return v;
  endfunction

  task automatic apply(input in_t v);
    flush          = v.fl;
    bus.dp_valid   = v.dv;
    bus.dp_rob_tag = v.tag;
    bus.dp_rs_rdy  = v.rsr;
    bus.dp_rs_tag  = v.rs_tg;
    bus.dp_rs_data = v.rsd;
    bus.dp_rt_rdy  = v.rtr;
    bus.dp_rt_tag  = v.rt_tg;
    bus.dp_rt_data = v.rtd;
    bus.dp_pc_1    = v.pc;
    bus.dp_instr   = v.ins;
    bus.dp_ctrl    = v.ctl;
    bus.cdb_valid  = v.cv;
    bus.cdb_tag    = v.ct;
    bus.cdb_data   = v.cd;
    bus.iss_ready  = v.ir;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1; apply(v.in); #1;
    chk($sformatf("v%0d.iss_valid", idx), 32'(bus.iss_valid), 32'(v.ev));
    chk($sformatf("v%0d.dp_ready", idx), 32'(bus.dp_ready), 32'(v.edr));
    chk($sformatf("v%0d.count", idx), 32'(bus.count), 32'(v.ec));
    if (v.ev) begin
      chk($sformatf("v%0d.iss_rob_tag", idx), 32'(bus.iss_rob_tag), 32'(v.et));
      chk($sformatf("v%0d.iss_rs_data", idx), bus.iss_rs_data, v.ers);
      chk($sformatf("v%0d.iss_rt_data", idx), bus.iss_rt_data, v.ert);
    end
  endtask

  // Reference: an age-ordered list; issue deletes, dispatch appends.
  task automatic model_cycle(input in_t v, input int n);
    int sel;
    logic exp_dr, exp_iv;
    m_ent_t e;
    @(posedge clk); #1; apply(v); #1;
    exp_dr = (mq.size() < DEPTH);
    sel = -1;
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].rs_rdy && mq[i].rt_rdy) sel = i;
    exp_iv = (sel >= 0) && !v.fl;
    chk($sformatf("r%0d.dp_ready", n), 32'(bus.dp_ready), 32'(exp_dr));
    chk($sformatf("r%0d.count", n), 32'(bus.count), 32'(mq.size()));
    chk($sformatf("r%0d.iss_valid", n), 32'(bus.iss_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk($sformatf("r%0d.iss_rob_tag", n), 32'(bus.iss_rob_tag), 32'(mq[sel].tag));
      chk($sformatf("r%0d.iss_rs_data", n), bus.iss_rs_data, mq[sel].rs);
      chk($sformatf("r%0d.iss_rt_data", n), bus.iss_rt_data, mq[sel].rt);
      chk($sformatf("r%0d.iss_pc_1", n), bus.iss_pc_1, mq[sel].pc);
      chk($sformatf("r%0d.iss_instr", n), bus.iss_instr, mq[sel].ins);
      chk($sformatf("r%0d.iss_ctrl", n), 32'(bus.iss_ctrl), 32'(mq[sel].ctl));
    end
    if (v.fl) begin
      mq.delete();
    end else begin
      if (exp_iv && v.ir) mq.delete(sel);
      if (v.cv) begin
        foreach (mq[i]) begin
          if (!mq[i].rs_rdy && mq[i].rs_tag == v.ct) begin mq[i].rs_rdy = 1'b1; mq[i].rs = v.cd; end
          if (!mq[i].rt_rdy && mq[i].rt_tag == v.ct) begin mq[i].rt_rdy = 1'b1; mq[i].rt = v.cd; end
        end
      end
      if (v.dv && exp_dr) begin
        e.tag = v.tag; e.pc = v.pc; e.ins = v.ins; e.ctl = v.ctl;
        e.rs_tag = v.rs_tg; e.rt_tag = v.rt_tg;
        e.rs_rdy = v.rsr || (v.cv && v.ct == v.rs_tg);
        e.rt_rdy = v.rtr || (v.cv && v.ct == v.rt_tg);
        e.rs = v.rsr ? v.rsd : v.cd;
        e.rt = v.rtr ? v.rtd : v.cd;
        mq.push_back(e);
      end
    end
  endtask

  function automatic in_t rnd();
    in_t v;
    v.fl = ($urandom_range(99) < 2);
    v.dv = ($urandom_range(99) < 60);
    v.ir = ($urandom_range(99) < 70);
    v.cv = ($urandom_range(99) < 50);
    v.rsr = ($urandom_range(99) < 50);
    v.rtr = ($urandom_range(99) < 50);
    v.tag = TAG_W'($urandom);
    v.rs_tg = TAG_W'($urandom_range(7));
    v.rt_tg = TAG_W'($urandom_range(7));
    v.ct = TAG_W'($urandom_range(7));
    v.rsd = $urandom; v.rtd = $urandom; v.cd = $urandom;
    v.pc = $urandom; v.ins = $urandom; v.ctl = 9'($urandom);
    return v;
  endfunction

  initial begin
    in_t idle;
    // fl dv tag  rsr rsg rsd     rtr rtg rtd   cv ct cd      ir | ev et ers     ert    dr cnt
    tbl.push_back(mk(0,1, 3, 1,0,'h10,  1,0,'h20, 0,0,0,      1, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 1,3,'h10,'h20,     1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,1, 1, 0,7,0,     1,0,'h2,  0,0,0,      1, 0,0,0,0,           1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0, 0,0,0,    0,0,0,    0,0,0,      1, 0,0,0,0,           1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    1,7,'hABCD, 1, 0,0,0,0,           1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 1,1,'hABCD,'h2,    1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,1, 2, 1,0,'h11,  0,5,0,    1,5,'h55,   1, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 1,2,'h11,'h55,     1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,1,10, 0,20,0,    1,0,'hA,  0,0,0,      0, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,1,11, 0,21,0,    1,0,'hB,  0,0,0,      0, 0,0,0,0,           1,1));
    tbl.push_back(mk(0,1,12, 0,22,0,    1,0,'hC,  0,0,0,      0, 0,0,0,0,           1,2));
    tbl.push_back(mk(0,1,13, 0,23,0,    1,0,'hD,  0,0,0,      0, 0,0,0,0,           1,3));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    1,22,'hC0,  0, 0,0,0,0,           0,4));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    1,20,'hA0,  0, 1,12,'hC0,'hC,     0,4));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      0, 1,10,'hA0,'hA,     0,4));
    tbl.push_back(mk(0,1,14, 1,0,'hE,   1,0,'hF,  0,0,0,      1, 1,10,'hA0,'hA,     0,4));
    tbl.push_back(mk(0,1,14, 1,0,'hE,   1,0,'hF,  0,0,0,      1, 1,12,'hC0,'hC,     1,3));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 1,14,'hE,'hF,      1,3));
    tbl.push_back(mk(0,1,15, 1,0,1,     1,0,1,    0,0,0,      0, 0,0,0,0,           1,2));
    tbl.push_back(mk(1,1,16, 1,0,2,     1,0,2,    0,0,0,      1, 0,0,0,0,           1,3));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    1,21,'h99,  1, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 0,0,0,0,           1,0));
    // issue of entry 0 while the entry behind it wakes up and slides down
    tbl.push_back(mk(0,1,20, 1,0,1,     1,0,2,    0,0,0,      0, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,1,21, 0,4,0,     1,0,3,    0,0,0,      0, 1,20,1,2,          1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    1,4,'h44,   1, 1,20,1,2,          1,2));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 1,21,'h44,3,       1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      1, 0,0,0,0,           1,0));
    // one broadcast wakes both operands of the same entry
    tbl.push_back(mk(0,1, 6, 0,9,0,     0,9,0,    0,0,0,      0, 0,0,0,0,           1,0));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    1,9,'h99,   0, 0,0,0,0,           1,1));
    tbl.push_back(mk(0,0, 0, 0,0,0,     0,0,0,    0,0,0,      0, 1,6,'h99,'h99,     1,1));
    tbl.push_back(mk(0,1, 7, 1,0,5,     1,0,5,    0,0,0,      0, 1,6,'h99,'h99,     1,1));

    idle = '{default: '0};
    apply(idle);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset.iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("reset.dp_ready", 32'(bus.dp_ready), 32'd1);
    chk("reset.count", 32'(bus.count), 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // asynchronous reset in the middle of a cycle with two live entries
    @(posedge clk); #1;
    idle.ir = 1'b1;
    apply(idle); #1;
    chk("midrst.pre_iss_valid", 32'(bus.iss_valid), 32'd1);
    chk("midrst.pre_count", 32'(bus.count), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("midrst.dp_ready", 32'(bus.dp_ready), 32'd1);
    chk("midrst.count", 32'(bus.count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_vec(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0, 1,0), 900);

    // randomized traffic against the list model, starting from an empty station
    idle = '{default: '0};
    apply(idle);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    mq.delete();
    for (int n = 0; n < N_RAND; n++) model_cycle(rnd(), n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
